hash_cmd_fifo: RTL and testbench

HASH_CMD_FIFO -- requirements
Module: hash_cmd_fifo

---
 rtl/hash_pkg.sv | 17 +
 rtl/hash_cmd_fifo.sv | 112 +++++++++++
 tb/tb_hash_cmd_fifo.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hash_pkg.sv
// Shared definitions for the hash-table command path: opcode values and
// the helper that locates the opcode field inside a command word.
package hash_pkg;

    localparam int unsigned OP_WIDTH = 2;

    localparam logic [OP_WIDTH-1:0] OP_NOP    = 2'b00;
    localparam logic [OP_WIDTH-1:0] OP_READ   = 2'b01;
    localparam logic [OP_WIDTH-1:0] OP_WRITE  = 2'b10;
    localparam logic [OP_WIDTH-1:0] OP_DELETE = 2'b11;

    // The opcode sits directly above {key, data}.
    function automatic int unsigned op_lsb(input int unsigned key_w, input int unsigned data_w);
        return key_w + data_w;
    endfunction

endpackage

// File: rtl/hash_cmd_fifo.sv
// First-word-fall-through command FIFO feeding the hash table; NOP commands
// are consumed at the input and only counted.
module hash_cmd_fifo
    import hash_pkg::*;
#(
    parameter int unsigned KEY_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 26,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [2+KEY_WIDTH+DATA_WIDTH-1:0]     s_data_i,
    input  logic                                  s_valid_i,
    output logic                                  s_ready_o,
    output logic [2+KEY_WIDTH+DATA_WIDTH-1:0]     m_data_o,
    output logic                                  m_valid_o,
    input  logic                                  m_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]            count_o,
    output logic [15:0]                           drop_count_o,
    output logic                                  full_o,
    output logic                                  empty_o
);

    localparam int unsigned CMD_WIDTH = 2 + KEY_WIDTH + DATA_WIDTH;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam int unsigned DROP_W    = 16;
    localparam int unsigned OP_LSB    = op_lsb(KEY_WIDTH, DATA_WIDTH);

    logic [CMD_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;

    logic [OP_WIDTH-1:0] s_op;
    logic                accept;
    logic                push;
    logic                drop;
    logic                pop;

    assign s_op   = s_data_i[OP_LSB +: OP_WIDTH];
    assign accept = s_valid_i && !full_q;
    assign push   = accept && (s_op != OP_NOP);
    assign drop   = accept && (s_op == OP_NOP);
    assign pop    = !empty_q && m_ready_i;

    // Next-state for pointers, occupancy, status flags and drop counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (drop && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + DROP_W'(1);
        end

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == CNT_W'(0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data_i;
        end
    end

    assign m_data_o     = mem_q[rd_ptr_q];
    assign m_valid_o    = !empty_q;
    assign s_ready_o    = !full_q;
    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign count_o      = count_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_hash_cmd_fifo.sv
// Directed bench for hash_cmd_fifo: the driver queues expected words, a
// negedge monitor checks every handshaked output word against that queue.
module tb_hash_cmd_fifo;
    import hash_pkg::*;

    localparam int unsigned KW  = 4;
    localparam int unsigned DW  = 26;
    localparam int unsigned DEP = 4;
    localparam int unsigned CW  = 2 + KW + DW;
    localparam int unsigned CNW = $clog2(DEP + 1);

    logic           clk;
    logic           reset;
    logic [CW-1:0]  s_data_i;
    logic           s_valid_i;
    logic           s_ready_o;
    logic [CW-1:0]  m_data_o;
    logic           m_valid_o;
    logic           m_ready_i;
    logic [CNW-1:0] count_o;
    logic [15:0]    drop_count_o;
    logic           full_o;
    logic           empty_o;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_q [$];

    hash_cmd_fifo #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .count_o      (count_o),
        .drop_count_o (drop_count_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] cmd(input logic [1:0] op, input int key, input int data);
        return {op, KW'(key), DW'(data)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a command for one edge; reads/writes/deletes are expected downstream.
    task automatic send(input logic [1:0] op, input int key, input int data);
        s_data_i  = cmd(op, key, data);
        s_valid_i = 1'b1;
        if (op != OP_NOP) exp_q.push_back(cmd(op, key, data));
        step();
        s_valid_i = 1'b0;
    endtask

    // Scoreboard monitor: a word visible with m_ready_i high is popped at the next edge.
    always @(negedge clk) begin
        if (!reset && m_valid_o && m_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %0h expected none", m_data_o);
            end else begin
                logic [CW-1:0] e;
                e = exp_q.pop_front();
                if (m_data_o !== e) begin
                    errors++;
                    $display("FAIL sb_order: got %0h expected %0h", m_data_o, e);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        m_ready_i = 1'b0;
        repeat (2) step();
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_mvalid", 64'(m_valid_o), 64'd0);
        check("rst_sready", 64'(s_ready_o), 64'd1);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_drop", 64'(drop_count_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Three writes with downstream stalled; first push lands on the first edge.
        send(OP_WRITE, 1, 'h10);
        check("lat_mvalid", 64'(m_valid_o), 64'd1);
        check("lat_mdata", 64'(m_data_o), 64'(cmd(OP_WRITE, 1, 'h10)));
        send(OP_WRITE, 2, 'h11);
        send(OP_WRITE, 3, 'h12);
        check("three_count", 64'(count_o), 64'd3);
        check("three_mvalid", 64'(m_valid_o), 64'd1);
        check("three_mdata", 64'(m_data_o), 64'(cmd(OP_WRITE, 1, 'h10)));

        // Fill, then hold a fifth word while full.
        send(OP_DELETE, 4, 'h13);
        check("full_full", 64'(full_o), 64'd1);
        check("full_sready", 64'(s_ready_o), 64'd0);
        s_data_i  = cmd(OP_READ, 5, 'h14);
        s_valid_i = 1'b1;
        repeat (2) step();
        check("full_hold_count", 64'(count_o), 64'd4);
        check("full_hold_mdata", 64'(m_data_o), 64'(cmd(OP_WRITE, 1, 'h10)));
        m_ready_i = 1'b1;
        step();
        m_ready_i = 1'b0;
        check("pop_sready", 64'(s_ready_o), 64'd1);
        check("pop_count", 64'(count_o), 64'd3);
        exp_q.push_back(cmd(OP_READ, 5, 'h14));
        step();
        s_valid_i = 1'b0;
        check("refill_count", 64'(count_o), 64'd4);

        // Drain down to two entries.
        m_ready_i = 1'b1;
        repeat (2) step();
        check("drain2_count", 64'(count_o), 64'd2);

        // Simultaneous push/pop for ten cycles; order checked by the monitor.
        for (int i = 0; i < 10; i++) begin
            s_data_i  = cmd(OP_WRITE, (i + 6) % 16, 'h20 + i);
            s_valid_i = 1'b1;
            exp_q.push_back(cmd(OP_WRITE, (i + 6) % 16, 'h20 + i));
            step();
            check($sformatf("pp_count_%0d", i), 64'(count_o), 64'd2);
        end
        s_valid_i = 1'b0;
        repeat (2) step();
        m_ready_i = 1'b0;
        check("pp_empty", 64'(empty_o), 64'd1);

        // NOPs interleaved with reads: only reads are stored.
        send(OP_NOP, 0, 'h0);
        send(OP_READ, 7, 'h30);
        send(OP_NOP, 1, 'h1);
        send(OP_READ, 9, 'h31);
        send(OP_NOP, 2, 'h2);
        check("nop_count", 64'(count_o), 64'd2);
        check("nop_drop", 64'(drop_count_o), 64'd3);
        m_ready_i = 1'b1;
        repeat (2) step();
        m_ready_i = 1'b0;
        check("nop_drained", 64'(empty_o), 64'd1);

        // Drive the drop counter into saturation.
        s_data_i  = cmd(OP_NOP, 0, 0);
        s_valid_i = 1'b1;
        repeat (65529) step();
        check("drop_near_sat", 64'(drop_count_o), 64'hFFFC);
        repeat (11) step();
        s_valid_i = 1'b0;
        check("drop_sat", 64'(drop_count_o), 64'hFFFF);
        check("drop_count_zero", 64'(count_o), 64'd0);

        // Reset in the middle of operation with three entries stored.
        send(OP_WRITE, 8, 'h40);
        send(OP_WRITE, 10, 'h41);
        send(OP_WRITE, 11, 'h42);
        check("mid_count", 64'(count_o), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_count", 64'(count_o), 64'd0);
        check("arst_mvalid", 64'(m_valid_o), 64'd0);
        check("arst_sready", 64'(s_ready_o), 64'd1);
        check("arst_drop", 64'(drop_count_o), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        send(OP_DELETE, 12, 'h50);
        check("post_rst_mvalid", 64'(m_valid_o), 64'd1);
        check("post_rst_mdata", 64'(m_data_o), 64'(cmd(OP_DELETE, 12, 'h50)));
        check("post_rst_count", 64'(count_o), 64'd1);
        m_ready_i = 1'b1;
        step();
        m_ready_i = 1'b0;
        repeat (2) step();
        check("post_rst_empty", 64'(empty_o), 64'd1);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
